conv_result_drain: RTL and testbench

Downstream stage of the convolution accelerator top level. It captures one full result frame when the accelerator pulses its output-valid strobe: OUT_SETS sets of DATA_OF_SET words. It then streams the frame out LANES words per beat over a valid/ready interface toward the vector register file writeback. It decouples the accelerator's single-cycle result pulse from a consumer that may stall.

---
 rtl/conv_result_drain_if.sv | 30 +++
 rtl/conv_result_drain.sv | 69 ++++++
 tb/tb_conv_result_drain.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/conv_result_drain_if.sv
// conv_result_drain_if: frame capture and beat streaming signals of the result drain.
// master = accelerator/consumer side, slave = the drain itself.
interface conv_result_drain_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_OF_SET = 128,
  parameter int OUT_SETS    = 8,
  parameter int LANES       = 4
);
  localparam int BPS = DATA_OF_SET / LANES;
  logic in_valid;
  logic in_ready;
  logic [OUT_SETS-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [LANES-1:0][DATA_WIDTH-1:0] out_data;
  logic [$clog2(OUT_SETS)-1:0] out_set;
  logic [$clog2(BPS)-1:0] out_idx;
  logic out_last;
  logic busy;
  logic overflow;
  logic overflow_clr;
  modport master (
    output in_valid, in_data, out_ready, overflow_clr,
    input  in_ready, out_valid, out_data, out_set, out_idx, out_last, busy, overflow
  );
  modport slave (
    input  in_valid, in_data, out_ready, overflow_clr,
    output in_ready, out_valid, out_data, out_set, out_idx, out_last, busy, overflow
  );
endinterface

// File: rtl/conv_result_drain.sv
// conv_result_drain: latches one accelerator result frame and streams it out LANES words per beat.
// Optional DRAIN_RELU_EN clamps negative words to 0 at capture.
module conv_result_drain #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_OF_SET = 128,
  parameter int OUT_SETS    = 8,
  parameter int LANES       = 4
) (
  input logic clk,
  input logic rst,
  conv_result_drain_if.slave bus
);
  localparam int BPS = DATA_OF_SET / LANES;
  localparam int SW  = $clog2(OUT_SETS);
  localparam int IW  = $clog2(BPS);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_n;
  logic [OUT_SETS-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] frame, cap;
  logic [SW-1:0] set_q;
  logic [IW-1:0] idx_q;
  logic ovf, capture, drop, fire, last, idx_wrap;
  assign capture  = state == IDLE && bus.in_valid;
  assign drop     = state == DRAIN && bus.in_valid;
  assign fire     = state == DRAIN && bus.out_ready;
  assign idx_wrap = idx_q == IW'(BPS - 1);
  assign last     = set_q == SW'(OUT_SETS - 1) && idx_wrap;
`ifdef DRAIN_RELU_EN
  always_comb begin
    cap = bus.in_data;
    for (int s = 0; s < OUT_SETS; s++)
      for (int w = 0; w < DATA_OF_SET; w++)
        cap[s][w] = bus.in_data[s][w][DATA_WIDTH-1] ? '0 : bus.in_data[s][w];
  end
`else
  assign cap = bus.in_data;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n       = capture ? DRAIN : (fire && last) ? IDLE : state;
    bus.in_ready  = state == IDLE;
    bus.busy      = state == DRAIN;
    bus.out_valid = state == DRAIN;
    bus.out_last  = state == DRAIN && last;
    bus.out_data  = state == DRAIN ? frame[set_q][int'(idx_q) * LANES +: LANES] : '0;
  end
  // Data buffer needs no reset: it is only observed while draining.
  always_ff @(posedge clk)
    if (capture) frame <= cap;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      set_q <= '0;
      idx_q <= '0;
    end else if (capture) begin
      set_q <= '0;
      idx_q <= '0;
    end else if (fire) begin
      idx_q <= idx_wrap ? '0 : idx_q + 1'b1;
      set_q <= last ? '0 : idx_wrap ? set_q + 1'b1 : set_q;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf <= 1'b0;
    else if (drop) ovf <= 1'b1;
    else if (bus.overflow_clr) ovf <= 1'b0;
  assign bus.out_set  = set_q;
  assign bus.out_idx  = idx_q;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_conv_result_drain.sv
// tb_conv_result_drain: random/directed frames checked by a beat scoreboard against a frame-level model.
module tb_conv_result_drain;
  localparam int DW = 32, DS = 128, OS = 8, LN = 4, BPS = DS / LN, NB = OS * BPS;
  typedef logic [LN-1:0][DW-1:0] beat_t;
  typedef struct {
    beat_t data;
    int    set;
    int    idx;
    bit    last;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0, failures = 0, popped = 0;
  bit exp_ovf = 1'b0, rand_rdy = 1'b0, busy_m;
  exp_t q[$];
  logic [OS-1:0][DS-1:0][DW-1:0] f;
  conv_result_drain_if #(.DATA_WIDTH(DW), .DATA_OF_SET(DS), .OUT_SETS(OS), .LANES(LN)) bus ();
  conv_result_drain #(.DATA_WIDTH(DW), .DATA_OF_SET(DS), .OUT_SETS(OS), .LANES(LN)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] word_m(input logic [DW-1:0] w);
`ifdef DRAIN_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction
  always @(posedge clk) begin
    #1;
    bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    busy_m = q.size() > 0;
    chk("out_valid", bus.out_valid, busy_m);
    chk("in_ready", bus.in_ready, !busy_m);
    chk("busy", bus.busy, busy_m);
    chk("overflow", bus.overflow, exp_ovf);
    if (!busy_m) chk("idle_data", bus.out_data, '0);
    else if (bus.out_valid) begin
      chk("beat_data", bus.out_data, q[0].data);
      chk("beat_set", bus.out_set, q[0].set);
      chk("beat_idx", bus.out_idx, q[0].idx);
      chk("beat_last", bus.out_last, q[0].last);
      if (bus.out_ready) begin
        void'(q.pop_front());
        popped++;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fill_pattern();
    for (int s = 0; s < OS; s++)
      for (int w = 0; w < DS; w++) f[s][w] = DW'(s * 1000 + w);
  endtask
  task automatic fill_random();
    for (int s = 0; s < OS; s++)
      for (int w = 0; w < DS; w++) f[s][w] = $urandom;
  endtask
  task automatic send();
    exp_t e;
    bus.in_data  = f;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    popped = 0;
    for (int k = 0; k < NB; k++) begin
      e.set  = k / BPS;
      e.idx  = k % BPS;
      e.last = k == NB - 1;
      for (int l = 0; l < LN; l++) e.data[l] = word_m(f[e.set][e.idx * LN + l]);
      q.push_back(e);
    end
  endtask
  task automatic wait_drain();
    int n = 0;
    while (q.size() > 0 && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 beats left", q.size());
      q.delete();
    end
    tick();
  endtask
  task automatic wait_popped(input int target);
    int n = 0;
    while (popped < target && n < 20000) begin
      tick();
      n++;
    end
    checks++;
    if (popped < target) begin
      failures++;
      $display("FAIL beat_wait actual=%0d required=%0d", popped, target);
    end
  endtask
  task automatic drop_pulse(input bit clr);
    fill_random();
    bus.in_data      = f;
    bus.in_valid     = 1'b1;
    bus.overflow_clr = clr;
    tick();
    bus.in_valid     = 1'b0;
    bus.overflow_clr = 1'b0;
    exp_ovf          = 1'b1;
  endtask
  initial begin
    bus.in_valid     = 1'b0;
    bus.overflow_clr = 1'b0;
    bus.in_data      = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    fill_pattern();
    send();
    wait_drain();
    rand_rdy = 1'b1;
    send();
    wait_drain();
    fill_random();
    send();
    wait_drain();
    rand_rdy = 1'b0;
    repeat (2) tick();
    fill_random();
    send();
    wait_popped(10);
    drop_pulse(1'b0);
    tick();
    drop_pulse(1'b1);
    tick();
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    begin
      int n = 0;
      while (q.size() > 1 && n < 20000) begin
        tick();
        n++;
      end
    end
    drop_pulse(1'b0);
    tick();
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    wait_drain();
    fill_random();
    send();
    wait_popped(100);
    rst = 1'b1;
    q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    fill_pattern();
    send();
    wait_drain();
    fill_random();
    f[0][0] = 32'hFFFF_FFFF;
    f[0][1] = 32'h8000_0000;
    f[0][2] = 32'h7FFF_FFFF;
    f[OS-1][DS-1] = 32'h8000_0000;
    rand_rdy = 1'b1;
    send();
    wait_drain();
    rand_rdy = 1'b0;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
